// File: rtl/exec_control_unit.sv
// Multi-cycle execute/memory/writeback sequencer for the RV32I/RV64I core.
// Every output is registered; memory traffic uses a req/ready handshake bounded by a timeout.
module exec_control_unit #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd_addr,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   alu_result,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              jump_en,
  output logic [XLEN-1:0]   jump_target,
  output logic              done,
  output logic              exc_misaligned,
  output logic              exc_illegal,
  output logic              exc_bus
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

  state_t            state_q, state_d;
  logic [6:0]        op_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   pc_q, rs1_q, rs2_q, imm_q;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              instr_ready_d, mem_req_d, mem_we_d, wb_we_d, jump_en_d, done_d;
  logic              exc_mis_d, exc_ill_d, exc_bus_d;
  logic [XLEN-1:0]   mem_addr_d, mem_wdata_d, wb_data_d, jump_target_d;
  logic [NB-1:0]     mem_be_d;
  logic [4:0]        wb_rd_d;

  logic [XLEN-1:0]   ea, pc4, ex_result, ex_target, wdata, shifted, load_data;
  logic [NB-1:0]     size_mask, be;
  logic [2:0]        align_mask;
  logic              addr_mis, ex_jump, ex_write, ex_mis, ex_ill, ex_mem;

  assign ea  = rs1_q + imm_q;
  assign pc4 = pc_q + XLEN'(4);

  // Access-size derived lane mask, alignment mask and replicated store data.
  always_comb begin
    size_mask  = '1;
    align_mask = 3'b111;
    wdata      = rs2_q;
    unique case (f3_q[1:0])
      2'd0: begin
        size_mask  = NB'(1);
        align_mask = 3'b000;
        for (int i = 0; i < NB; i++) wdata[8*i +: 8] = rs2_q[7:0];
      end
      2'd1: begin
        size_mask  = NB'(3);
        align_mask = 3'b001;
        for (int i = 0; i < NB/2; i++) wdata[16*i +: 16] = rs2_q[15:0];
      end
      2'd2: begin
        size_mask  = NB'(15);
        align_mask = 3'b011;
        for (int i = 0; i < NB/4; i++) wdata[32*i +: 32] = rs2_q[31:0];
      end
      default: ;
    endcase
  end

  assign addr_mis = |(ea[2:0] & align_mask);
  assign be       = size_mask << ea[OW-1:0];
  assign shifted  = mem_rdata >> {mem_addr[OW-1:0], 3'b000};

  always_comb begin
    load_data = shifted;
    unique case (f3_q[1:0])
      2'd0: load_data = f3_q[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'd1: load_data = f3_q[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'd2: load_data = f3_q[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ;
    endcase
  end

  // Opcode decode for the EXEC cycle; exceptions suppress both the jump and the write.
  always_comb begin
    ex_result = '0;
    ex_target = '0;
    ex_jump   = 1'b0;
    ex_write  = 1'b0;
    ex_mis    = 1'b0;
    ex_ill    = 1'b0;
    ex_mem    = 1'b0;
    unique case (op_q)
      OPC_OP, OPC_OPIMM: begin
        ex_result = alu_result;
        ex_write  = 1'b1;
      end
      OPC_LUI: begin
        ex_result = imm_q;
        ex_write  = 1'b1;
      end
      OPC_AUIPC: begin
        ex_result = pc_q + imm_q;
        ex_write  = 1'b1;
      end
      OPC_JAL: begin
        ex_target = pc_q + imm_q;
        ex_result = pc4;
        ex_write  = 1'b1;
        ex_jump   = 1'b1;
        ex_mis    = ex_target[1];
      end
      OPC_JALR: begin
        ex_target = {ea[XLEN-1:1], 1'b0};
        ex_result = pc4;
        ex_ill    = (f3_q != 3'b000);
        ex_write  = 1'b1;
        ex_jump   = 1'b1;
        ex_mis    = ex_target[1];
      end
      OPC_BRANCH: begin
        ex_target = pc_q + imm_q;
        unique case (f3_q)
          3'b000:  ex_jump = (rs1_q == rs2_q);
          3'b001:  ex_jump = (rs1_q != rs2_q);
          3'b100:  ex_jump = ($signed(rs1_q) <  $signed(rs2_q));
          3'b101:  ex_jump = ($signed(rs1_q) >= $signed(rs2_q));
          3'b110:  ex_jump = (rs1_q <  rs2_q);
          3'b111:  ex_jump = (rs1_q >= rs2_q);
          default: ex_ill  = 1'b1;
        endcase
        ex_mis = ex_jump & ex_target[1];
      end
      OPC_LOAD: begin
        ex_ill = (f3_q == 3'b111) ||
                 ((XLEN != 64) && ((f3_q == 3'b011) || (f3_q == 3'b110)));
        ex_mis = ~ex_ill & addr_mis;
        ex_mem = ~ex_ill & ~addr_mis;
      end
      OPC_STORE: begin
        ex_ill = f3_q[2] || ((XLEN != 64) && (f3_q[1:0] == 2'b11));
        ex_mis = ~ex_ill & addr_mis;
        ex_mem = ~ex_ill & ~addr_mis;
      end
      default: ex_ill = 1'b1;
    endcase
    if (ex_mis || ex_ill) begin
      ex_jump  = 1'b0;
      ex_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state plus the value every registered output takes on the coming edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    instr_ready_d = 1'b0;
    mem_req_d     = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    mem_be_d      = '0;
    wb_we_d       = 1'b0;
    wb_rd_d       = '0;
    wb_data_d     = '0;
    jump_en_d     = 1'b0;
    jump_target_d = '0;
    done_d        = 1'b0;
    exc_mis_d     = 1'b0;
    exc_ill_d     = 1'b0;
    exc_bus_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_ready_d = ~instr_valid;
        if (instr_valid) state_d = EXEC;
      end
      EXEC: begin
        if (ex_mem) begin
          state_d     = MEM;
          mem_req_d   = 1'b1;
          mem_we_d    = (op_q == OPC_STORE);
          mem_addr_d  = ea;
          mem_be_d    = be;
          mem_wdata_d = (op_q == OPC_STORE) ? wdata : '0;
        end else begin
          state_d       = WB;
          done_d        = 1'b1;
          wb_we_d       = ex_write && (rd_q != 5'd0);
          wb_rd_d       = rd_q;
          wb_data_d     = ex_result;
          jump_en_d     = ex_jump;
          jump_target_d = ex_target;
          exc_mis_d     = ex_mis;
          exc_ill_d     = ex_ill;
        end
      end
      MEM: begin
        if (mem_ready) begin
          state_d = WB;
          done_d  = 1'b1;
          wb_rd_d = rd_q;
          if (!mem_we) begin
            wb_we_d   = (rd_q != 5'd0);
            wb_data_d = load_data;
          end
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d   = WB;
          done_d    = 1'b1;
          wb_rd_d   = rd_q;
          exc_bus_d = 1'b1;
        end else begin
          cnt_d       = cnt_q + CW'(1);
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we;
          mem_addr_d  = mem_addr;
          mem_wdata_d = mem_wdata;
          mem_be_d    = mem_be;
        end
      end
      WB: begin
        state_d       = IDLE;
        instr_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= '0;
      f3_q  <= '0;
      rd_q  <= '0;
      pc_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else if (state_q == IDLE && instr_valid) begin
      op_q  <= opcode;
      f3_q  <= funct3;
      rd_q  <= rd_addr;
      pc_q  <= pc;
      rs1_q <= rs1;
      rs2_q <= rs2;
      imm_q <= imm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      instr_ready    <= 1'b1;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      wb_we          <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      jump_en        <= 1'b0;
      jump_target    <= '0;
      done           <= 1'b0;
      exc_misaligned <= 1'b0;
      exc_illegal    <= 1'b0;
      exc_bus        <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      instr_ready    <= instr_ready_d;
      mem_req        <= mem_req_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
      mem_be         <= mem_be_d;
      wb_we          <= wb_we_d;
      wb_rd          <= wb_rd_d;
      wb_data        <= wb_data_d;
      jump_en        <= jump_en_d;
      jump_target    <= jump_target_d;
      done           <= done_d;
      exc_misaligned <= exc_mis_d;
      exc_illegal    <= exc_ill_d;
      exc_bus        <= exc_bus_d;
    end
  end

endmodule

// File: tb/tb_exec_control_unit.sv
// Directed testbench for exec_control_unit (XLEN=32, MEM_TIMEOUT=16).
// Latency is counted to the clock edge at which done is first sampled high.
module tb_exec_control_unit;

  localparam int XLEN        = 32;
  localparam int MEM_TIMEOUT = 16;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid, instr_ready;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [4:0]        rd_addr;
  logic [XLEN-1:0]   pc, rs1, rs2, imm, alu_result;
  logic              mem_req, mem_we, mem_ready;
  logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;
  logic [XLEN/8-1:0] mem_be;
  logic              wb_we, jump_en, done;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data, jump_target;
  logic              exc_misaligned, exc_illegal, exc_bus;

  int checks = 0;
  int fails  = 0;

  int                lat;
  int                reqCycles;
  logic              capWe;
  logic [XLEN-1:0]   capAddr, capWdata;
  logic [XLEN/8-1:0] capBe;
  logic              sawDone;

  always #5 clk = ~clk;

  exec_control_unit #(.XLEN(XLEN), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct3(funct3), .rd_addr(rd_addr),
    .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_result(alu_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .jump_en(jump_en), .jump_target(jump_target), .done(done),
    .exc_misaligned(exc_misaligned), .exc_illegal(exc_illegal), .exc_bus(exc_bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Waits for instr_ready, presents one instruction and returns 1ns after the accept edge.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                               input logic [31:0] pcv, input logic [31:0] rs1v, input logic [31:0] rs2v,
                               input logic [31:0] immv, input logic [31:0] aluv);
    bit ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr_ready) begin
        ready = 1'b1;
        break;
      end
    end
    if (!ready) checkOutput("accept_timeout", {63'd0, instr_ready}, 64'd1);
    opcode      = op;
    funct3      = f3;
    rd_addr     = rd;
    pc          = pcv;
    rs1         = rs1v;
    rs2         = rs2v;
    imm         = immv;
    alu_result  = aluv;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  // Runs the memory responder until done; mem_ready rises after waitCycles stalled MEM cycles.
  task automatic waitDone(input int waitCycles, input logic [31:0] rdata);
    lat       = -1;
    reqCycles = 0;
    capWe     = 1'b0;
    capAddr   = '0;
    capWdata  = '0;
    capBe     = '0;
    mem_rdata = rdata;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        reqCycles++;
        capWe    = mem_we;
        capAddr  = mem_addr;
        capWdata = mem_wdata;
        capBe    = mem_be;
      end
      mem_ready = mem_req && (reqCycles > waitCycles);
      if (done) begin
        lat = k + 1;
        break;
      end
    end
    mem_ready = 1'b0;
    if (lat < 0) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    instr_valid = 1'b0;
    opcode = '0; funct3 = '0; rd_addr = '0;
    pc = '0; rs1 = '0; rs2 = '0; imm = '0; alu_result = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_instr_ready", {63'd0, instr_ready}, 64'd1);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_mem_req", {63'd0, mem_req}, 64'd0);
    checkOutput("rst_wb_we", {63'd0, wb_we}, 64'd0);
    checkOutput("rst_exc", {61'd0, exc_misaligned, exc_illegal, exc_bus}, 64'd0);
    rst = 1'b1;

    // ADD x3 = 5 + 7
    applyStimulus(OPC_OP, 3'b000, 5'd3, 32'h0, 32'd5, 32'd7, 32'd0, 32'd12);
    waitDone(0, 32'h0);
    checkOutput("add_latency", 64'(lat), 64'd2);
    checkOutput("add_wb_we", {63'd0, wb_we}, 64'd1);
    checkOutput("add_wb_rd", {59'd0, wb_rd}, 64'd3);
    checkOutput("add_wb_data", {32'd0, wb_data}, 64'd12);
    checkOutput("add_jump_en", {63'd0, jump_en}, 64'd0);
    @(posedge clk); #1;
    checkOutput("add_done_pulse", {63'd0, done}, 64'd0);
    checkOutput("add_ready_back", {63'd0, instr_ready}, 64'd1);

    // ADD to x0 must not write
    applyStimulus(OPC_OP, 3'b000, 5'd0, 32'h0, 32'd1, 32'd1, 32'd0, 32'd2);
    waitDone(0, 32'h0);
    checkOutput("add_x0_wb_we", {63'd0, wb_we}, 64'd0);

    // AUIPC x7 = 0x1000 + 0x12345000
    applyStimulus(OPC_AUIPC, 3'b000, 5'd7, 32'h1000, 32'd0, 32'd0, 32'h12345000, 32'd0);
    waitDone(0, 32'h0);
    checkOutput("auipc_wb_data", {32'd0, wb_data}, 64'h12346000);

    // LB from 0x103 with two wait states
    applyStimulus(OPC_LOAD, 3'b000, 5'd4, 32'h0, 32'h100, 32'd0, 32'd3, 32'd0);
    waitDone(2, 32'h80FF_0000);
    checkOutput("lb_latency", 64'(lat), 64'd5);
    checkOutput("lb_mem_addr", {32'd0, capAddr}, 64'h103);
    checkOutput("lb_mem_be", {60'd0, capBe}, 64'b1000);
    checkOutput("lb_mem_we", {63'd0, capWe}, 64'd0);
    checkOutput("lb_wb_data", {32'd0, wb_data}, 64'hFFFF_FF80);
    checkOutput("lb_wb_we", {63'd0, wb_we}, 64'd1);

    // LBU, same access
    applyStimulus(OPC_LOAD, 3'b100, 5'd4, 32'h0, 32'h100, 32'd0, 32'd3, 32'd0);
    waitDone(2, 32'h80FF_0000);
    checkOutput("lbu_wb_data", {32'd0, wb_data}, 64'h80);

    // SH misaligned at 0x101
    applyStimulus(OPC_STORE, 3'b001, 5'd0, 32'h0, 32'h101, 32'hABCD, 32'd0, 32'd0);
    waitDone(0, 32'h0);
    checkOutput("sh_mis_latency", 64'(lat), 64'd2);
    checkOutput("sh_mis_no_req", 64'(reqCycles), 64'd0);
    checkOutput("sh_mis_flag", {63'd0, exc_misaligned}, 64'd1);
    checkOutput("sh_mis_wb_we", {63'd0, wb_we}, 64'd0);

    // SH aligned at 0x102, ready on the first MEM cycle
    applyStimulus(OPC_STORE, 3'b001, 5'd0, 32'h0, 32'h100, 32'hABCD, 32'd2, 32'd0);
    waitDone(0, 32'h0);
    checkOutput("sh_latency", 64'(lat), 64'd3);
    checkOutput("sh_mem_be", {60'd0, capBe}, 64'b1100);
    checkOutput("sh_mem_wdata", {32'd0, capWdata}, 64'hABCD_ABCD);
    checkOutput("sh_mem_we", {63'd0, capWe}, 64'd1);
    checkOutput("sh_wb_we", {63'd0, wb_we}, 64'd0);

    // Signed vs unsigned branches: -1 vs 1
    applyStimulus(OPC_BRANCH, 3'b100, 5'd0, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'd0);
    waitDone(0, 32'h0);
    checkOutput("blt_jump_en", {63'd0, jump_en}, 64'd1);
    checkOutput("blt_target", {32'd0, jump_target}, 64'h38);
    checkOutput("blt_wb_we", {63'd0, wb_we}, 64'd0);
    applyStimulus(OPC_BRANCH, 3'b110, 5'd0, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'd0);
    waitDone(0, 32'h0);
    checkOutput("bltu_jump_en", {63'd0, jump_en}, 64'd0);
    applyStimulus(OPC_BRANCH, 3'b111, 5'd0, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'd0);
    waitDone(0, 32'h0);
    checkOutput("bgeu_jump_en", {63'd0, jump_en}, 64'd1);
    applyStimulus(OPC_BRANCH, 3'b010, 5'd0, 32'h40, 32'd0, 32'd0, 32'd8, 32'd0);
    waitDone(0, 32'h0);
    checkOutput("br_f3_illegal", {63'd0, exc_illegal}, 64'd1);
    checkOutput("br_f3_ill_jump", {63'd0, jump_en}, 64'd0);

    // JALR clears bit 0 of the target and links pc+4
    applyStimulus(OPC_JALR, 3'b000, 5'd1, 32'h40, 32'h201, 32'd0, 32'd0, 32'd0);
    waitDone(0, 32'h0);
    checkOutput("jalr_target", {32'd0, jump_target}, 64'h200);
    checkOutput("jalr_jump_en", {63'd0, jump_en}, 64'd1);
    checkOutput("jalr_wb_data", {32'd0, wb_data}, 64'h44);
    checkOutput("jalr_wb_we", {63'd0, wb_we}, 64'd1);

    // JAL to 0x42 is misaligned
    applyStimulus(OPC_JAL, 3'b000, 5'd1, 32'h40, 32'd0, 32'd0, 32'd2, 32'd0);
    waitDone(0, 32'h0);
    checkOutput("jal_mis_flag", {63'd0, exc_misaligned}, 64'd1);
    checkOutput("jal_mis_jump", {63'd0, jump_en}, 64'd0);
    checkOutput("jal_mis_wb_we", {63'd0, wb_we}, 64'd0);

    // LWU is RV64-only
    applyStimulus(OPC_LOAD, 3'b110, 5'd2, 32'h0, 32'h100, 32'd0, 32'd0, 32'd0);
    waitDone(0, 32'h0);
    checkOutput("lwu_illegal", {63'd0, exc_illegal}, 64'd1);
    checkOutput("lwu_no_req", 64'(reqCycles), 64'd0);

    // SW with memory never ready
    applyStimulus(OPC_STORE, 3'b010, 5'd0, 32'h0, 32'h200, 32'h1234_5678, 32'd0, 32'd0);
    waitDone(1000, 32'h0);
    checkOutput("to_req_cycles", 64'(reqCycles), 64'(MEM_TIMEOUT));
    checkOutput("to_latency", 64'(lat), 64'(MEM_TIMEOUT + 2));
    checkOutput("to_exc_bus", {63'd0, exc_bus}, 64'd1);
    checkOutput("to_wb_we", {63'd0, wb_we}, 64'd0);
    @(posedge clk); #1;
    checkOutput("to_ready_back", {63'd0, instr_ready}, 64'd1);
    checkOutput("to_exc_pulse", {63'd0, exc_bus}, 64'd0);

    // Asynchronous reset while a load is stalled in MEM
    applyStimulus(OPC_LOAD, 3'b010, 5'd5, 32'h0, 32'h300, 32'd0, 32'd0, 32'd0);
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("arst_req_before", {63'd0, mem_req}, 64'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_mem_req", {63'd0, mem_req}, 64'd0);
    checkOutput("arst_mem_addr", {32'd0, mem_addr}, 64'd0);
    checkOutput("arst_instr_ready", {63'd0, instr_ready}, 64'd1);
    checkOutput("arst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    sawDone = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("arst_no_stale_done", {63'd0, sawDone}, 64'd0);
    applyStimulus(OPC_OP, 3'b000, 5'd9, 32'h0, 32'd20, 32'd22, 32'd0, 32'd42);
    waitDone(0, 32'h0);
    checkOutput("post_rst_latency", 64'(lat), 64'd2);
    checkOutput("post_rst_wb_data", {32'd0, wb_data}, 64'd42);
    checkOutput("post_rst_wb_rd", {59'd0, wb_rd}, 64'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
